// File: rtl/signed_mac_acc_pkg.sv
// Shared types and constants for the signed accumulate stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gsm_pkg;

    // Default configuration matching the multiplier it normally follows.
    localparam int P_W_DEF   = 16;
    localparam int ACC_W_DEF = 24;
    localparam int CNT_N_DEF = 8;

    // ACC: taking products; HOLD: a finished block waits for the consumer.
    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Largest positive two's-complement value representable in w bits.
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Most negative two's-complement value representable in w bits.
    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/signed_mac_acc_sat_add.sv
// Saturating signed adder: acc + addend clamped to the ACC_W range.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module sat_add
    import gsm_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0] i_acc,
    input  logic signed [ACC_W-1:0] i_add,
    output logic signed [ACC_W-1:0] o_sum,
    output logic                    o_clamp
);

    localparam logic signed [ACC_W-1:0] C_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] C_MIN = ACC_W'(sat_min(ACC_W));

    // One guard bit is enough: the sum of two ACC_W values fits ACC_W+1.
    logic signed [ACC_W:0] w_wide;

    assign w_wide = {i_acc[ACC_W-1], i_acc} + {i_add[ACC_W-1], i_add};

    // Overflow shows as guard bit and sign bit disagreeing; the guard bit
    // carries the true sign and so picks which rail to clamp to.
    always_comb begin
        o_sum   = w_wide[ACC_W-1:0];
        o_clamp = 1'b0;
        if (w_wide[ACC_W] != w_wide[ACC_W-1]) begin
            o_clamp = 1'b1;
            o_sum   = w_wide[ACC_W] ? C_MIN : C_MAX;
        end
    end

endmodule

// File: rtl/signed_mac_acc.sv
// Sums CNT_N signed products with saturation and a sticky per-block overflow flag.
// Latency: result valid the cycle after the CNT_N-th accepted product.
// Backpressure: in_ready drops while a finished block waits for out_ready.
module signed_mac_acc
    import gsm_pkg::*;
#(
    parameter int P_W   = P_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_N = CNT_N_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [P_W-1:0]   in_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam int              CNT_W  = (CNT_N > 1) ? $clog2(CNT_N) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CNT_N - 1);

    state_t                  r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_ovf_s;
    logic [ACC_W-1:0]        r_out_sum;
    logic                    r_out_ovf;
    logic                    r_out_valid;

    state_t                  w_state_nxt;
    logic signed [ACC_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    w_ovf_s_nxt;
    logic [ACC_W-1:0]        w_out_sum_nxt;
    logic                    w_out_ovf_nxt;
    logic                    w_out_valid_nxt;

    logic signed [ACC_W-1:0] w_p_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_clamp;
    logic                    w_accept;

    assign w_p_ext  = ACC_W'($signed(in_p));
    assign in_ready = (r_state == ST_ACC);
    assign w_accept = in_valid && in_ready;

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_ovf   = r_out_ovf;

    sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .i_acc   (r_acc),
        .i_add   (w_p_ext),
        .o_sum   (w_sum),
        .o_clamp (w_clamp)
    );

    // Next-state and register update logic; clr overrides any handshake.
    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
        w_ovf_s_nxt     = r_ovf_s;
        w_out_sum_nxt   = r_out_sum;
        w_out_ovf_nxt   = r_out_ovf;
        w_out_valid_nxt = r_out_valid;

        if (clr) begin
            w_state_nxt     = ST_ACC;
            w_acc_nxt       = '0;
            w_cnt_nxt       = '0;
            w_ovf_s_nxt     = 1'b0;
            w_out_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_accept) begin
                        if (r_cnt == C_LAST) begin
                            w_out_sum_nxt   = w_sum;
                            w_out_ovf_nxt   = r_ovf_s | w_clamp;
                            w_out_valid_nxt = 1'b1;
                            w_acc_nxt       = '0;
                            w_cnt_nxt       = '0;
                            w_ovf_s_nxt     = 1'b0;
                            w_state_nxt     = ST_HOLD;
                        end else begin
                            w_acc_nxt   = w_sum;
                            w_cnt_nxt   = r_cnt + CNT_W'(1);
                            w_ovf_s_nxt = r_ovf_s | w_clamp;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        w_out_valid_nxt = 1'b0;
                        w_state_nxt     = ST_ACC;
                    end
                end
                default: begin
                    w_state_nxt = ST_ACC;
                end
            endcase
        end
    end

    // State, accumulator and output registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_ACC;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf_s     <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ovf_s     <= w_ovf_s_nxt;
            r_out_sum   <= w_out_sum_nxt;
            r_out_ovf   <= w_out_ovf_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

endmodule

// File: tb/tb_signed_mac_acc.sv
// Bench for signed_mac_acc: a 24-bit and a 17-bit accumulator share stimulus.
// Latency: block result checked when out_valid & out_ready at the negedge.
// Backpressure: out_ready is stalled explicitly in a hand-written sequence.
module tb_signed_mac_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic [15:0] in_p;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_ovf_a;
    logic [23:0] out_sum_a;
    logic        in_ready_b, out_valid_b, out_ovf_b;
    logic [16:0] out_sum_b;

    int n_pass = 0;
    int n_tot  = 0;

    int qa_sum[$];
    bit qa_ovf[$];
    int qb_sum[$];
    bit qb_ovf[$];

    typedef struct {
        int p [4];
        int sa;
        bit oa;
        int sb;
        bit ob;
    } vec_t;

    vec_t vt [5];

    signed_mac_acc #(.P_W(16), .ACC_W(24), .CNT_N(4)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .in_p      (in_p),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .out_sum   (out_sum_a),
        .out_ovf   (out_ovf_a)
    );

    signed_mac_acc #(.P_W(16), .ACC_W(17), .CNT_N(4)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .in_p      (in_p),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .out_sum   (out_sum_b),
        .out_ovf   (out_ovf_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Drives four products on consecutive cycles, then idles one cycle.
    task automatic drive_block(input vec_t v, input bit push);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_p     = 16'(v.p[k]);
        end
        if (push) begin
            qa_sum.push_back(v.sa);
            qa_ovf.push_back(v.oa);
            qb_sum.push_back(v.sb);
            qb_ovf.push_back(v.ob);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic vec_t mk(input int p0, input int p1, input int p2, input int p3,
                                input int sa, input bit oa, input int sb, input bit ob);
        vec_t v;
        v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3;
        v.sa = sa; v.oa = oa; v.sb = sb; v.ob = ob;
        return v;
    endfunction

    // Scoreboard: every output handshake pops and checks one expected block.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid_a && out_ready) begin
                if (qa_sum.size() == 0) begin
                    chk("a_unexpected_result", 1, 0);
                end else begin
                    chk("a_sum", int'($signed(out_sum_a)), qa_sum.pop_front());
                    chk("a_ovf", out_ovf_a, qa_ovf.pop_front());
                end
            end
            if (out_valid_b && out_ready) begin
                if (qb_sum.size() == 0) begin
                    chk("b_unexpected_result", 1, 0);
                end else begin
                    chk("b_sum", int'($signed(out_sum_b)), qb_sum.pop_front());
                    chk("b_ovf", out_ovf_b, qb_ovf.pop_front());
                end
            end
        end
    end

    initial begin
        vt[0] = mk(100, -50, 3, -1,             52,      0, 52,     0);
        vt[1] = mk(-32768, -32768, -32768, -32768, -131072, 0, -65536, 1);
        vt[2] = mk(32767, 32767, 32767, 32767,  131068,  0, 65535,  1);
        vt[3] = mk(1, 1, 1, 1,                  4,       0, 4,      0);
        vt[4] = mk(32767, 32767, 32767, -32768, 65533,   0, 32767,  1);

        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_p = '0; out_ready = 1'b1;
        #3;
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_out_sum",   out_sum_a,   0);
        chk("rst_out_ovf",   out_ovf_a,   0);
        chk("rst_in_ready",  in_ready_a,  1);
        chk("rst_in_ready_b", in_ready_b, 1);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven blocks, results checked by the scoreboard.
        for (int i = 0; i < 5; i++) drive_block(vt[i], 1'b1);

        // Completion cycle: result visible, input side closed.
        drive_block(mk(2, 2, 2, 2, 8, 0, 8, 0), 1'b1);
        @(negedge clk);

        // Backpressure: result must hold and 7s must not be consumed.
        out_ready = 1'b0;
        drive_block(mk(1, 2, 3, 4, 10, 0, 10, 0), 1'b1);
        chk("bp_in_ready_done", in_ready_a, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_p     = 16'd7;
            chk("bp_out_valid", out_valid_a, 1);
            chk("bp_in_ready",  in_ready_a,  0);
            chk("bp_out_sum",   int'($signed(out_sum_a)), 10);
            chk("bp_out_valid_b", out_valid_b, 1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_release_valid", out_valid_a, 0);
        chk("bp_release_ready", in_ready_a,  1);
        drive_block(mk(7, 7, 7, 7, 28, 0, 28, 0), 1'b1);

        // clr after a partial sum, with a same-cycle product that must be dropped.
        @(negedge clk); in_valid = 1'b1; in_p = 16'd10;
        @(negedge clk); in_p = 16'd20;
        @(negedge clk); clr = 1'b1; in_p = 16'd5;
        @(negedge clk); clr = 1'b0; in_valid = 1'b0;
        chk("clr_in_ready",  in_ready_a,  1);
        chk("clr_out_valid", out_valid_a, 0);
        drive_block(mk(1, 1, 1, 1, 4, 0, 4, 0), 1'b1);
        @(negedge clk);

        // Asynchronous reset while a result is held.
        out_ready = 1'b0;
        drive_block(mk(1, 2, 3, 4, 10, 0, 10, 0), 1'b0);
        chk("hold_before_rst", out_valid_a, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid_a, 0);
        chk("arst_out_sum",   out_sum_a,   0);
        chk("arst_out_ovf",   out_ovf_a,   0);
        chk("arst_in_ready",  in_ready_a,  1);
        chk("arst_out_valid_b", out_valid_b, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;

        // Post-reset block proves accumulation restarts from zero.
        drive_block(mk(-5, 3, -2, 1, -3, 0, -3, 0), 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_empty_a", qa_sum.size(), 0);
        chk("scoreboard_empty_b", qb_sum.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
